// File: rtl/priority_arbiter.sv
// Four-requester arbiter with fixed-priority or round-robin selection and a
// bounded hold time per grant; all outputs are registered.
module priority_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       mode,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       valid
);

  localparam int unsigned CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [CW-1:0] hold_cnt;
  logic [1:0]    ptr;

  logic [3:0] cand;
  logic       owner_req;
  logic       win_found;
  logic [1:0] win_id;
  logic [1:0] idx;

  assign owner_req = |(req & grant);

  // On expiry the current owner is excluded; on release or from IDLE all
  // requesters compete.
  always_comb begin
    cand = req;
    if (state == GRANT && owner_req) cand = req & ~grant;
    win_found = |cand;
    win_id    = '0;
    idx       = '0;
    if (!mode) begin
      for (int unsigned i = 0; i < 4; i++)
        if (cand[i]) win_id = 2'(i);
    end else begin
      // Walk from farthest to nearest so the nearest hit after ptr wins.
      for (int unsigned k = 4; k >= 1; k--) begin
        idx = ptr + 2'(k);
        if (cand[idx]) win_id = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      valid    <= 1'b0;
      hold_cnt <= '0;
      ptr      <= 2'b11;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= GRANT;
            grant    <= 4'(1) << win_id;
            grant_id <= win_id;
            valid    <= 1'b1;
            ptr      <= win_id;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (!owner_req || hold_cnt == LAST) begin
            hold_cnt <= '0;
            if (win_found) begin
              grant    <= 4'(1) << win_id;
              grant_id <= win_id;
              valid    <= 1'b1;
              ptr      <= win_id;
            end else if (!owner_req) begin
              state    <= IDLE;
              grant    <= '0;
              grant_id <= '0;
              valid    <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 8, maximum consecutive cycles one requester may hold a grant (legal range 2..255).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req  input  4  request vector; req[i]=1 means requester i wants the resource.
REQ-005 Port: mode  input  1  0 = fixed priority (req[3] highest, req[0] lowest); 1 = round robin.
REQ-006 Port: grant  output  4  registered one-hot grant; all-zero when no owner.
REQ-007 Port: grant_id  output  2  registered binary index of current owner; 0 when valid=0.
REQ-008 Port: valid  output  1  registered; 1 when grant is nonzero.

Function
REQ-009 The block SHALL implement two states: IDLE (no owner) and GRANT (one owner).
REQ-010 IDLE: if req is nonzero at a rising edge, the block SHALL enter GRANT and drive grant/grant_id/valid for the winner from that edge onward (1-cycle latency, req to grant).
REQ-011 Fixed mode: the winner SHALL be the highest-index set bit of the candidate set.
REQ-012 Round-robin mode: the winner SHALL be the first set bit found searching indices ptr+1, ptr+2, ... modulo 4.
REQ-013 ptr (2 bits, internal) SHALL load grant_id on every new grant; it SHALL update in fixed mode as well.
REQ-014 hold_cnt SHALL be 0 in the first grant cycle and increment by 1 each cycle the same grant continues; width SHALL cover MAX_HOLD-1 without wrap.
REQ-015 GRANT, owner req high and hold_cnt < MAX_HOLD-1: grant SHALL remain unchanged.
REQ-016 GRANT, owner req low: the block SHALL re-arbitrate at that edge over req; if req is nonzero, the new grant SHALL appear on the next cycle with no idle bubble; if req is zero, the block SHALL go to IDLE with grant=0, valid=0, grant_id=0.
REQ-017 GRANT, owner req high and hold_cnt = MAX_HOLD-1 (expiry): the candidate set SHALL be req with the owner's bit cleared; if nonempty, the winner SHALL be granted next cycle; if empty, the owner SHALL be re-granted with hold_cnt restarting at 0.
REQ-018 mode SHALL be sampled only at arbitration edges (IDLE with req nonzero, release, expiry); changes mid-grant SHALL NOT affect the current owner.
REQ-019 grant SHALL be one-hot or zero in every cycle, and grant[grant_id] SHALL equal valid.
REQ-020 Requests from non-owners SHALL NOT disturb the current grant before release or expiry.

Reset
REQ-021 While rst=1, the block SHALL immediately force state=IDLE, grant=4'b0000, grant_id=2'b00, valid=0, hold_cnt=0, ptr=2'b11, independent of clk.
REQ-022 Reset asserted mid-grant SHALL drop grant in the same cycle; after deassertion the first arbitration SHALL behave as from power-up (round robin starts search at index 0).

Verification
REQ-023 Bench SHALL cover: mode=0, req=4'b0101 after reset -> next cycle grant=4'b0100, grant_id=2, valid=1; hold while req[2]=1.
REQ-024 Bench SHALL cover: mode=1, req=4'b1111 held constant, MAX_HOLD=8 -> grants 0,1,2,3,0 each lasting exactly 8 cycles, back-to-back.
REQ-025 Bench SHALL cover: owner 1 drops req while req=4'b1000 -> next cycle grant=4'b1000 with no zero cycle; then req=0 -> next cycle grant=0, valid=0, grant_id=0.
REQ-026 Bench SHALL cover: single requester req=4'b0010 held 20 cycles, MAX_HOLD=8 -> grant=4'b0010 continuously, hold_cnt restarts at cycles 8 and 16.
REQ-027 Bench SHALL cover: rst pulsed between clock edges during grant=4'b0100 -> outputs zero before the next edge; after release, mode=1, req=4'b1001 -> grant=4'b0001.
REQ-028 Bench SHALL check REQ-019 every cycle and dump a VCD of all ports.
